// File: rtl/dragon_pursuit_if.sv
// Step/entity inputs and dragon status outputs for dragon_pursuit.
// The slave modport is the dragon side; the master modport is the game/driver side.
interface dragon_pursuit_if #(
  parameter int unsigned COORD_W = 4,
  parameter int unsigned LEN_W   = 4
);
  logic                   step;
  logic [2*COORD_W-1:0]   player_loc;
  logic [2*COORD_W-1:0]   sheep_loc;
  logic                   player_hit;
  logic [2*COORD_W-1:0]   head_loc;
  logic [1:0]             head_dir;
  logic [LEN_W-1:0]       body_len;
  logic [1:0]             state;
  logic                   moved;
  logic                   sheep_eaten;
  logic                   player_caught;
  logic                   dead;

  modport master (
    output step, player_loc, sheep_loc, player_hit,
    input  head_loc, head_dir, body_len, state, moved, sheep_eaten, player_caught, dead
  );

  modport slave (
    input  step, player_loc, sheep_loc, player_hit,
    output head_loc, head_dir, body_len, state, moved, sheep_eaten, player_caught, dead
  );
endinterface

// File: rtl/dragon_pursuit.sv
// Tile-stepping dragon: chases the nearer of player/sheep, retreats when hit, scatters after a
// catch. Define DRAGON_LFSR_SCATTER_EN for an LFSR-chosen scatter target (else top-left corner).
module dragon_pursuit #(
  parameter int unsigned          COORD_W       = 4,
  parameter int unsigned          LEN_W         = 4,
  parameter int unsigned          INIT_LEN      = 3,
  parameter logic [2*COORD_W-1:0] START_LOC     = 8'h77,
  parameter int unsigned          RETREAT_STEPS = 6,
  parameter int unsigned          SCATTER_STEPS = 8
) (
  input logic             frame_clk,
  input logic             rst_n,
  dragon_pursuit_if.slave io_bus
);
  localparam int unsigned LocW     = 2 * COORD_W;
  localparam int unsigned MaxSteps = (RETREAT_STEPS > SCATTER_STEPS) ? RETREAT_STEPS
                                                                     : SCATTER_STEPS;
  localparam int unsigned CntW     = $clog2(MaxSteps + 1);

  localparam logic [1:0] StContest = 2'b00;
  localparam logic [1:0] StRetreat = 2'b01;
  localparam logic [1:0] StScatter = 2'b10;
  localparam logic [1:0] StDead    = 2'b11;

  localparam logic [1:0] DirUp    = 2'b00;
  localparam logic [1:0] DirRight = 2'b01;
  localparam logic [1:0] DirDown  = 2'b10;
  localparam logic [1:0] DirLeft  = 2'b11;

  localparam logic [COORD_W-1:0] COne   = COORD_W'(1);
  localparam logic [LEN_W-1:0]   LOne   = LEN_W'(1);
  localparam logic [CntW-1:0]    CntOne = CntW'(1);

  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  logic [LocW-1:0]    r_head, w_head_d;
  logic [1:0]         r_dir, w_dir_d;
  logic [LEN_W-1:0]   r_len, w_len_d;
  logic [1:0]         r_state, w_state_d;
  logic [CntW-1:0]    r_cnt, w_cnt_d, w_cnt_dec;
  logic               r_moved, w_moved_d;
  logic               r_eaten, w_eaten_d;
  logic               r_caught, w_caught_d;

  logic [LocW-1:0]    w_star, w_tgt, w_next;
  logic [COORD_W-1:0] w_hx, w_hy, w_tx, w_ty, w_adx, w_ady;
  logic [COORD_W:0]   w_dist_s, w_dist_p;
  logic               w_mv, w_hit_sheep, w_hit_player;
  logic [1:0]         w_mdir;

  assign w_hx = r_head[COORD_W-1:0];
  assign w_hy = r_head[LocW-1:COORD_W];

  // Target selection; a distance tie goes to the sheep.
  always_comb begin
    w_dist_s = {1'b0, abs_diff(io_bus.sheep_loc[COORD_W-1:0], w_hx)}
             + {1'b0, abs_diff(io_bus.sheep_loc[LocW-1:COORD_W], w_hy)};
    w_dist_p = {1'b0, abs_diff(io_bus.player_loc[COORD_W-1:0], w_hx)}
             + {1'b0, abs_diff(io_bus.player_loc[LocW-1:COORD_W], w_hy)};
    w_tgt = r_head;
    unique case (r_state)
      StContest: w_tgt = (w_dist_p < w_dist_s) ? io_bus.player_loc : io_bus.sheep_loc;
      StRetreat: w_tgt = {{COORD_W{~io_bus.player_loc[LocW-1]}},
                          {COORD_W{~io_bus.player_loc[COORD_W-1]}}};
      StScatter: w_tgt = w_star;
      default:   w_tgt = r_head;
    endcase
  end

  // One tile on one axis toward the target; x wins when |dx| >= |dy|.
  always_comb begin
    w_tx   = w_tgt[COORD_W-1:0];
    w_ty   = w_tgt[LocW-1:COORD_W];
    w_adx  = abs_diff(w_tx, w_hx);
    w_ady  = abs_diff(w_ty, w_hy);
    w_next = r_head;
    w_mv   = 1'b0;
    w_mdir = r_dir;
    if ((w_adx >= w_ady) && (w_adx != '0)) begin
      w_mv = 1'b1;
      if (w_tx > w_hx) begin
        w_next[COORD_W-1:0] = w_hx + COne;
        w_mdir              = DirRight;
      end else begin
        w_next[COORD_W-1:0] = w_hx - COne;
        w_mdir              = DirLeft;
      end
    end else if (w_ady != '0) begin
      w_mv = 1'b1;
      if (w_ty > w_hy) begin
        w_next[LocW-1:COORD_W] = w_hy + COne;
        w_mdir                 = DirDown;
      end else begin
        w_next[LocW-1:COORD_W] = w_hy - COne;
        w_mdir                 = DirUp;
      end
    end
  end

  assign w_hit_sheep  = (w_next == io_bus.sheep_loc);
  assign w_hit_player = (w_next == io_bus.player_loc);
  assign w_cnt_dec    = (r_cnt == '0) ? '0 : r_cnt - CntOne;

  always_comb begin
    w_head_d   = r_head;
    w_dir_d    = r_dir;
    w_len_d    = r_len;
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_moved_d  = 1'b0;
    w_eaten_d  = 1'b0;
    w_caught_d = 1'b0;
    if (io_bus.step && (r_state != StDead)) begin
      if (io_bus.player_hit) begin
        w_len_d = (r_len == '0) ? '0 : r_len - LOne;
        if (r_len <= LOne) begin
          w_state_d = StDead;
        end else begin
          w_state_d = StRetreat;
          w_cnt_d   = CntW'(RETREAT_STEPS);
        end
      end else begin
        w_head_d  = w_next;
        w_moved_d = w_mv;
        w_dir_d   = w_mdir;
        if (r_state == StContest) begin
          if (w_hit_sheep || w_hit_player) begin
            w_state_d = StScatter;
            w_cnt_d   = CntW'(SCATTER_STEPS);
          end
          if (w_hit_sheep) begin
            w_eaten_d = 1'b1;
            w_len_d   = (r_len == '1) ? r_len : r_len + LOne;
          end
          w_caught_d = w_hit_player;
        end else begin
          w_cnt_d = w_cnt_dec;
          if ((w_next == w_tgt) || (w_cnt_dec == '0)) w_state_d = StContest;
        end
      end
    end
  end

  always_ff @(posedge frame_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head   <= START_LOC;
      r_dir    <= DirLeft;
      r_len    <= LEN_W'(INIT_LEN);
      r_state  <= StScatter;
      r_cnt    <= CntW'(SCATTER_STEPS);
      r_moved  <= 1'b0;
      r_eaten  <= 1'b0;
      r_caught <= 1'b0;
    end else begin
      r_head   <= w_head_d;
      r_dir    <= w_dir_d;
      r_len    <= w_len_d;
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_moved  <= w_moved_d;
      r_eaten  <= w_eaten_d;
      r_caught <= w_caught_d;
    end
  end

`ifdef DRAGON_LFSR_SCATTER_EN
  localparam logic [15:0] LfsrSeed = 16'hACE1;
  logic [15:0]     r_lfsr;
  logic [LocW-1:0] r_star;

  // Fibonacci taps 16,14,13,11; target captured only on entry into scatter.
  always_ff @(posedge frame_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= LfsrSeed;
      r_star <= LfsrSeed[LocW-1:0];
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      if ((w_state_d == StScatter) && (r_state != StScatter)) r_star <= r_lfsr[LocW-1:0];
    end
  end
  assign w_star = r_star;
`else
  assign w_star = '0;
`endif

  assign io_bus.head_loc      = r_head;
  assign io_bus.head_dir      = r_dir;
  assign io_bus.body_len      = r_len;
  assign io_bus.state         = r_state;
  assign io_bus.moved         = r_moved;
  assign io_bus.sheep_eaten   = r_eaten;
  assign io_bus.player_caught = r_caught;
  assign io_bus.dead          = (r_state == StDead);
endmodule

// File: doc/dragon_pursuit.md
DRAGON_PURSUIT -- requirements
Module: dragon_pursuit

Interface
REQ-001 SHALL have parameter COORD_W, default 4: bits per axis, legal range 2..8; a location is {y,x} and is 2*COORD_W bits wide.
REQ-002 SHALL have parameter LEN_W, default 4: body-length width; MAX_LEN = 2^LEN_W-1.
REQ-003 SHALL have parameter INIT_LEN, default 3: body length after reset; legal range 1..MAX_LEN.
REQ-004 SHALL have parameter START_LOC, default 8'h77: head location after reset.
REQ-005 SHALL have parameter RETREAT_STEPS, default 6: step budget for the RETREAT state.
REQ-006 SHALL have parameter SCATTER_STEPS, default 8: step budget for the SCATTER state.
REQ-007 SHALL have port frame_clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-009 SHALL have port step, input, 1 bit: one-cycle strobe meaning "advance one tile this cycle".
REQ-010 SHALL have ports player_loc and sheep_loc, input, 2*COORD_W bits each: current entity locations.
REQ-011 SHALL have port player_hit, input, 1 bit: player strikes the dragon; sampled only when step=1.
REQ-012 SHALL have outputs head_loc (2*COORD_W), head_dir (2: UP=00, RIGHT=01, DOWN=10, LEFT=11), body_len (LEN_W) and state (2: CONTEST=00, RETREAT=01, SCATTER=10, DEAD=11), all registered.
REQ-013 SHALL have outputs moved, sheep_eaten and player_caught, 1 bit each: one-cycle pulses.
REQ-014 SHALL have output dead, 1 bit: level, equal to (state==DEAD).

Function
REQ-015 SHALL ignore all inputs when step=0: every register holds and every pulse output is 0.
REQ-016 SHALL set the target by state: CONTEST uses the closer of player and sheep by Manhattan distance (COORD_W+1-bit sum, no overflow), and a tie selects the sheep.
REQ-017 SHALL set the RETREAT target per axis: the axis coordinate is all-ones when the player's coordinate MSB is 0, else all-zeros.
REQ-018 SHALL use the scatter-target register as the SCATTER target.
REQ-019 SHALL move at most one tile on one axis per step, never diagonally: move on x when |dx|>=|dy| and dx!=0, else on y when dy!=0, else stay.
REQ-020 SHALL never wrap coordinates.
REQ-021 SHALL, on a step where the head moves, pulse moved and set head_dir to the movement direction; head_dir SHALL hold when the head does not move.
REQ-022 SHALL give player_hit in any non-DEAD state priority over all other step events: no move, body_len-1; body_len reaching 0 goes to DEAD, otherwise goes to RETREAT with retreat counter = RETREAT_STEPS.
REQ-023 SHALL, in CONTEST, compare the post-move head against the sheep and the player; on either match go to SCATTER, load the scatter target and set the scatter counter = SCATTER_STEPS.
REQ-024 SHALL, on a sheep match, pulse sheep_eaten and increment body_len, saturating at MAX_LEN.
REQ-025 SHALL, on a player match, pulse player_caught; when both match on the same step, both pulses fire and the sheep increment applies.
REQ-026 SHALL, in RETREAT and SCATTER, decrement the state's counter per step and go to CONTEST when the post-move head equals the target or the counter reaches 0, whichever occurs first.
REQ-027 SHALL treat DEAD as absorbing until reset: step is ignored and outputs hold.
REQ-028 SHALL produce outputs reflecting a step on the clock edge at which step is sampled (latency 1 cycle).

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force head_loc=START_LOC, head_dir=LEFT, body_len=INIT_LEN, state=SCATTER, scatter counter=SCATTER_STEPS, all pulses 0, dead=0, LFSR=16'hACE1.
REQ-030 SHALL, when reset is asserted mid-step, abandon the step, apply REQ-029, and act on no step until the first edge after rst_n rises.

Configuration
REQ-031 SHALL, with macro DRAGON_LFSR_SCATTER_EN defined, include a 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances every clock, with the scatter target = LFSR[2*COORD_W-1:0] captured on entry to SCATTER and at reset.
REQ-032 SHALL, with DRAGON_LFSR_SCATTER_EN undefined, omit the LFSR and use the fixed scatter target all-zeros (the top-left corner).

Verification
REQ-033 SHALL cover reset: assert rst_n=0 mid-run -> head_loc=8'h77, head_dir=LEFT, body_len=3, state=SCATTER, with no clock edge needed.
REQ-034 SHALL cover single-axis pursuit: CONTEST, head 8'h22, sheep 8'h55, player 8'hFF, 6 steps -> path 23,33,34,44,45,55; never diagonal; sheep_eaten pulse on step 6; body_len 3->4; state SCATTER.
REQ-035 SHALL cover tie-break: CONTEST, head 8'h44, sheep 8'h46, player 8'h42 -> head 8'h45, head_dir RIGHT.
REQ-036 SHALL cover hurt: body_len=1, step with player_hit=1 -> body_len 0, state DEAD, dead=1; 5 further steps -> head_loc unchanged, moved=0.
REQ-037 SHALL cover retreat: player_hit with body_len=3, player 8'h31 -> state RETREAT, target 8'hFF; after 6 steps without reaching it -> state CONTEST.
REQ-038 SHALL cover saturation: body_len=15 and the sheep is eaten -> body_len stays 15, sheep_eaten=1.
